pcie_cfg_arbiter: RTL and testbench
===================================

// Module: pcie_cfg_arbiter
// PURPOSE
//  Shares the Root Port config packet generator and completion decoder between two requesters:
//  r0 = boot-time ROM configurator, r1 = runtime host config-access path (driver CfgRd/CfgWr).
//  Accepts one request at a time, issues the TLP and waits for pkt_done.
//  Then waits for the completion, retrying CRS automatically and bounding the wait with a timeout.
//  Returns status and data to the owning requester.
// PARAMETERS
//  FIXED_PRIO     1        1: r0 always wins; 0: round-robin (last granted loses ties)
//  TO_WIDTH       16       width of completion-timeout counter
//  CPL_TIMEOUT    50000    cycles in ST_WAIT_CPL before timeout status (< 2**TO_WIDTH)
//  MAX_CRS_RETRY  8        CRS retransmissions before reporting CRS-exhausted (1..15)
// PORTS
//  user_clk       in   1   clock
//  reset_n        in   1   asynchronous active-low reset
//  rN_req_valid   in   1   (N=0,1) request pending; hold with hdr/data stable until rN_req_ready
//  rN_req_hdr     in   18  {type[17:16],func[15:14],reg[13:4],be[3:0]}; msg routing=[10:8], code=[7:0]
//  rN_req_data    in   32  write/message payload
//  rN_req_ready   out  1   1-cycle accept pulse
//  rN_rsp_valid   out  1   1-cycle response pulse
//  rN_rsp_status  out  3   0 SC/msg sent, 1 UR, 2 CA, 3 CRS exhausted, 4 mismatch, 5 timeout
//  rN_rsp_data    out  32  cpl_data on SC, else 0
//  pkt_type, pkt_func_num, pkt_reg_num, pkt_1dw_be  out  2,2,10,4  TLP header fields to generator
//  pkt_msg_routing, pkt_msg_code                     out  3,8      message fields (same hdr bits)
//  pkt_data       out  32  TLP payload
//  pkt_start      out  1   1-cycle start pulse to packet generator
//  pkt_done       in   1   generator finished transmitting TLP
//  cpl_sc, cpl_ur, cpl_crs, cpl_ca, cpl_mismatch  in  1 each  completion decoder strobes
//  cpl_data       in   32  completion payload, valid with cpl_sc
//  busy           out  1   state != ST_IDLE
//  owner          out  1   requester holding the grant (0=r0, 1=r1)
// BEHAVIOUR
//  Reset: all outputs 0; state ST_IDLE; last_grant=1 (r0 wins first round-robin tie).
//   Counters cleared. Reset mid-operation abandons the transaction with no response.
//  ST_IDLE: if any rN_req_valid, pick winner.
//   FIXED_PRIO=1: r0 wins. FIXED_PRIO=0: the non-last_grant requester wins when both request.
//   Same cycle: pulse winner rN_req_ready; latch hdr/data into pkt_* regs; set owner, last_grant.
//   Clear timeout and retry counters; -> ST_ISSUE. Loser keeps valid high and waits.
//  ST_ISSUE: pkt_start=1 for exactly this cycle; -> ST_WAIT_PKT.
//  ST_WAIT_PKT: on pkt_done: if pkt_type[1]=1 (MSG/MSGD) -> ST_RESP, status 0; else -> ST_WAIT_CPL.
//   Timeout counter cleared on entry to ST_WAIT_CPL.
//  ST_WAIT_CPL: cpl_* sampled only here.
//   Priority when several strobes coincide: SC > CRS > UR > CA > mismatch.
//   SC -> ST_RESP, status 0, capture cpl_data.
//   CRS: if retry_cnt < MAX_CRS_RETRY -> retry_cnt+1, ST_ISSUE (same latched TLP);
//    else -> ST_RESP, status 3.
//   UR/CA/mismatch -> ST_RESP, status 1/2/4.
//   No strobe: timeout counter +1. On the cycle counter == CPL_TIMEOUT-1 -> ST_RESP, status 5.
//   A strobe on the timeout cycle wins over timeout.
//  ST_RESP: pulse rN_rsp_valid for owner with status/data (data 0 unless SC); -> ST_IDLE.
//   Earliest next accept is the cycle after ST_RESP: minimum 4 cycles request-to-request.
//  Outside ST_WAIT_CPL, cpl_* strobes are ignored (stray completions dropped).
//  pkt_done outside ST_WAIT_PKT is ignored.
//  Counters saturate, never wrap.
//  pkt_* fields hold their values from accept until the next accept.
//  rN_rsp_* hold until the next response to the same requester; only rsp_valid pulses.
// TESTING
//  r1 CfgRd hdr=18'h0_0004F, pkt_done, cpl_sc data=32'hDEAD_BEEF
//   -> one pkt_start, r1_rsp_valid, status 0, data DEADBEEF.
//  r0 and r1 both valid in same cycle, FIXED_PRIO=1 -> r0 granted first, r1 granted in the
//   ST_IDLE cycle after r0 response. FIXED_PRIO=0 -> two back-to-back contention rounds alternate.
//  r0 CfgWr, 3 CRS then SC -> 4 pkt_start pulses, status 0.
//  r0 CfgWr, 9 CRS with MAX_CRS_RETRY=8 -> 9 pkt_start pulses, then status 3.
//  r1 message type 2'b10 -> response status 0 right after pkt_done; cpl_sc then ignored.
//  CfgRd with no completion, CPL_TIMEOUT=20 -> status 5 exactly 20 cycles after ST_WAIT_CPL
//   entry. cpl_sc and cpl_ur together -> status 0.
//  Assert reset_n low during ST_WAIT_CPL -> outputs 0 immediately, no rsp_valid.
//   After release, a new request completes normally.

Source files
------------

// File: rtl/pcie_cfg_arbiter.sv
// pcie_cfg_arbiter
// Shares the Root Port config TLP generator and completion decoder between the
// boot-time ROM configurator (r0) and the runtime host config path (r1). One
// transaction is in flight at a time; CRS completions are retried automatically
// and the completion wait is bounded by a timeout.
module pcie_cfg_arbiter #(
  parameter int FIXED_PRIO    = 1,
  parameter int TO_WIDTH      = 16,
  parameter int CPL_TIMEOUT   = 50000,
  parameter int MAX_CRS_RETRY = 8
) (
  input  logic        user_clk,
  input  logic        reset_n,
  input  logic        r0_req_valid,
  input  logic [17:0] r0_req_hdr,
  input  logic [31:0] r0_req_data,
  output logic        r0_req_ready,
  output logic        r0_rsp_valid,
  output logic [2:0]  r0_rsp_status,
  output logic [31:0] r0_rsp_data,
  input  logic        r1_req_valid,
  input  logic [17:0] r1_req_hdr,
  input  logic [31:0] r1_req_data,
  output logic        r1_req_ready,
  output logic        r1_rsp_valid,
  output logic [2:0]  r1_rsp_status,
  output logic [31:0] r1_rsp_data,
  output logic [1:0]  pkt_type,
  output logic [1:0]  pkt_func_num,
  output logic [9:0]  pkt_reg_num,
  output logic [3:0]  pkt_1dw_be,
  output logic [2:0]  pkt_msg_routing,
  output logic [7:0]  pkt_msg_code,
  output logic [31:0] pkt_data,
  output logic        pkt_start,
  input  logic        pkt_done,
  input  logic        cpl_sc,
  input  logic        cpl_ur,
  input  logic        cpl_crs,
  input  logic        cpl_ca,
  input  logic        cpl_mismatch,
  input  logic [31:0] cpl_data,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_PKT,
    ST_WAIT_CPL,
    ST_RESP
  } state_t;

  localparam logic [2:0] STS_OK       = 3'd0;
  localparam logic [2:0] STS_UR       = 3'd1;
  localparam logic [2:0] STS_CA       = 3'd2;
  localparam logic [2:0] STS_CRS      = 3'd3;
  localparam logic [2:0] STS_MISMATCH = 3'd4;
  localparam logic [2:0] STS_TIMEOUT  = 3'd5;

  localparam logic [TO_WIDTH-1:0] TO_LAST   = TO_WIDTH'(CPL_TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] TO_ONE    = TO_WIDTH'(1);
  localparam logic [3:0]          RETRY_MAX = 4'(MAX_CRS_RETRY);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [17:0]         hdr_q, hdr_d;
  logic [31:0]         data_q, data_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]          retry_q, retry_d;
  logic [2:0]          rsp0_status_q, rsp0_status_d, rsp1_status_q, rsp1_status_d;
  logic [31:0]         rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

  logic                grant_sel;
  logic                ready0, ready1;
  logic                rsp_load;
  logic [2:0]          rsp_status;
  logic [31:0]         rsp_data;

  // Pick the requester that would win if the arbiter accepts this cycle (1 = r1).
  always_comb begin
    grant_sel = 1'b0;
    if (!r0_req_valid) begin
      grant_sel = 1'b1;
    end else if ((FIXED_PRIO == 0) && r1_req_valid) begin
      grant_sel = ~last_grant_q;
    end
  end

  // Transaction FSM: accept, issue TLP, wait for completion/retry/timeout, respond.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    hdr_d        = hdr_q;
    data_d       = data_q;
    to_cnt_d     = to_cnt_q;
    retry_d      = retry_q;
    ready0       = 1'b0;
    ready1       = 1'b0;
    rsp_load     = 1'b0;
    rsp_status   = STS_OK;
    rsp_data     = '0;
    case (state_q)
      ST_IDLE: begin
        if (r0_req_valid || r1_req_valid) begin
          ready0       = ~grant_sel;
          ready1       = grant_sel;
          hdr_d        = grant_sel ? r1_req_hdr : r0_req_hdr;
          data_d       = grant_sel ? r1_req_data : r0_req_data;
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          to_cnt_d     = '0;
          retry_d      = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_PKT;
      ST_WAIT_PKT: begin
        if (pkt_done) begin
          if (hdr_q[17]) begin
            rsp_load = 1'b1;
            state_d  = ST_RESP;
          end else begin
            to_cnt_d = '0;
            state_d  = ST_WAIT_CPL;
          end
        end
      end
      ST_WAIT_CPL: begin
        if (cpl_sc) begin
          rsp_load = 1'b1;
          rsp_data = cpl_data;
          state_d  = ST_RESP;
        end else if (cpl_crs) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_ISSUE;
          end else begin
            rsp_load   = 1'b1;
            rsp_status = STS_CRS;
            state_d    = ST_RESP;
          end
        end else if (cpl_ur) begin
          rsp_load   = 1'b1;
          rsp_status = STS_UR;
          state_d    = ST_RESP;
        end else if (cpl_ca) begin
          rsp_load   = 1'b1;
          rsp_status = STS_CA;
          state_d    = ST_RESP;
        end else if (cpl_mismatch) begin
          rsp_load   = 1'b1;
          rsp_status = STS_MISMATCH;
          state_d    = ST_RESP;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_load   = 1'b1;
          rsp_status = STS_TIMEOUT;
          state_d    = ST_RESP;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers per requester; only the owner's copy is updated.
  always_comb begin
    rsp0_status_d = rsp0_status_q;
    rsp0_data_d   = rsp0_data_q;
    rsp1_status_d = rsp1_status_q;
    rsp1_data_d   = rsp1_data_q;
    if (rsp_load) begin
      if (owner_q) begin
        rsp1_status_d = rsp_status;
        rsp1_data_d   = rsp_data;
      end else begin
        rsp0_status_d = rsp_status;
        rsp0_data_d   = rsp_data;
      end
    end
  end

  // State and datapath registers; last_grant resets to r1 so r0 wins the first tie.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      hdr_q         <= '0;
      data_q        <= '0;
      to_cnt_q      <= '0;
      retry_q       <= '0;
      rsp0_status_q <= '0;
      rsp0_data_q   <= '0;
      rsp1_status_q <= '0;
      rsp1_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      hdr_q         <= hdr_d;
      data_q        <= data_d;
      to_cnt_q      <= to_cnt_d;
      retry_q       <= retry_d;
      rsp0_status_q <= rsp0_status_d;
      rsp0_data_q   <= rsp0_data_d;
      rsp1_status_q <= rsp1_status_d;
      rsp1_data_q   <= rsp1_data_d;
    end
  end

  // Ready is combinational from valid, so hold it low while reset is asserted.
  assign r0_req_ready    = ready0 & reset_n;
  assign r1_req_ready    = ready1 & reset_n;
  assign r0_rsp_valid    = (state_q == ST_RESP) && !owner_q;
  assign r1_rsp_valid    = (state_q == ST_RESP) && owner_q;
  assign r0_rsp_status   = rsp0_status_q;
  assign r0_rsp_data     = rsp0_data_q;
  assign r1_rsp_status   = rsp1_status_q;
  assign r1_rsp_data     = rsp1_data_q;
  assign pkt_type        = hdr_q[17:16];
  assign pkt_func_num    = hdr_q[15:14];
  assign pkt_reg_num     = hdr_q[13:4];
  assign pkt_1dw_be      = hdr_q[3:0];
  assign pkt_msg_routing = hdr_q[10:8];
  assign pkt_msg_code    = hdr_q[7:0];
  assign pkt_data        = data_q;
  assign pkt_start       = (state_q == ST_ISSUE);
  assign busy            = (state_q != ST_IDLE);
  assign owner           = owner_q;

endmodule

// File: tb/tb_pcie_cfg_arbiter.sv
// tb_pcie_cfg_arbiter
// Directed bench for pcie_cfg_arbiter. The main instance runs with fixed priority
// and a short completion timeout; a second instance runs round-robin arbitration.
module tb_pcie_cfg_arbiter;

  logic user_clk = 1'b0;
  logic reset_n;

  // Main instance signals
  logic        r0_req_valid, r1_req_valid;
  logic [17:0] r0_req_hdr, r1_req_hdr;
  logic [31:0] r0_req_data, r1_req_data;
  logic        r0_req_ready, r1_req_ready;
  logic        r0_rsp_valid, r1_rsp_valid;
  logic [2:0]  r0_rsp_status, r1_rsp_status;
  logic [31:0] r0_rsp_data, r1_rsp_data;
  logic [1:0]  pkt_type, pkt_func_num;
  logic [9:0]  pkt_reg_num;
  logic [3:0]  pkt_1dw_be;
  logic [2:0]  pkt_msg_routing;
  logic [7:0]  pkt_msg_code;
  logic [31:0] pkt_data;
  logic        pkt_start, pkt_done;
  logic        cpl_sc, cpl_ur, cpl_crs, cpl_ca, cpl_mismatch;
  logic [31:0] cpl_data;
  logic        busy, owner;

  // Round-robin instance signals
  logic        rr_r0_req_valid, rr_r1_req_valid;
  logic        rr_r0_req_ready, rr_r1_req_ready;
  logic        rr_r0_rsp_valid, rr_r1_rsp_valid;
  logic [2:0]  rr_r0_rsp_status, rr_r1_rsp_status;
  logic [31:0] rr_r0_rsp_data, rr_r1_rsp_data;
  logic [1:0]  rr_pkt_type, rr_pkt_func_num;
  logic [9:0]  rr_pkt_reg_num;
  logic [3:0]  rr_pkt_1dw_be;
  logic [2:0]  rr_pkt_msg_routing;
  logic [7:0]  rr_pkt_msg_code;
  logic [31:0] rr_pkt_data;
  logic        rr_pkt_start, rr_pkt_done, rr_cpl_sc;
  logic        rr_busy, rr_owner;

  // Bookkeeping
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int start_cnt = 0, r0_rsp_cnt = 0, r1_rsp_cnt = 0, r0_acc_cnt = 0, r1_acc_cnt = 0;
  int rr_start_cnt = 0, rr_r0_rsp_cnt = 0, rr_r1_rsp_cnt = 0, rr_r0_acc = 0, rr_r1_acc = 0;
  int r0_rsp_cyc = 0, r1_acc_cyc = 0;
  int r0_acc_seen = 0, r1_acc_seen = 0, rr_r0_seen = 0, rr_r1_seen = 0;
  int t_entry = 0;

  always #5 user_clk = ~user_clk;

  pcie_cfg_arbiter #(
    .FIXED_PRIO(1), .TO_WIDTH(16), .CPL_TIMEOUT(20), .MAX_CRS_RETRY(8)
  ) u_dut (
    .user_clk(user_clk), .reset_n(reset_n),
    .r0_req_valid(r0_req_valid), .r0_req_hdr(r0_req_hdr), .r0_req_data(r0_req_data),
    .r0_req_ready(r0_req_ready), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_status(r0_rsp_status), .r0_rsp_data(r0_rsp_data),
    .r1_req_valid(r1_req_valid), .r1_req_hdr(r1_req_hdr), .r1_req_data(r1_req_data),
    .r1_req_ready(r1_req_ready), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_status(r1_rsp_status), .r1_rsp_data(r1_rsp_data),
    .pkt_type(pkt_type), .pkt_func_num(pkt_func_num), .pkt_reg_num(pkt_reg_num),
    .pkt_1dw_be(pkt_1dw_be), .pkt_msg_routing(pkt_msg_routing), .pkt_msg_code(pkt_msg_code),
    .pkt_data(pkt_data), .pkt_start(pkt_start), .pkt_done(pkt_done),
    .cpl_sc(cpl_sc), .cpl_ur(cpl_ur), .cpl_crs(cpl_crs), .cpl_ca(cpl_ca),
    .cpl_mismatch(cpl_mismatch), .cpl_data(cpl_data), .busy(busy), .owner(owner)
  );

  pcie_cfg_arbiter #(
    .FIXED_PRIO(0), .TO_WIDTH(16), .CPL_TIMEOUT(20), .MAX_CRS_RETRY(8)
  ) u_rr (
    .user_clk(user_clk), .reset_n(reset_n),
    .r0_req_valid(rr_r0_req_valid), .r0_req_hdr(18'h0004F), .r0_req_data(32'h0),
    .r0_req_ready(rr_r0_req_ready), .r0_rsp_valid(rr_r0_rsp_valid),
    .r0_rsp_status(rr_r0_rsp_status), .r0_rsp_data(rr_r0_rsp_data),
    .r1_req_valid(rr_r1_req_valid), .r1_req_hdr(18'h0004F), .r1_req_data(32'h0),
    .r1_req_ready(rr_r1_req_ready), .r1_rsp_valid(rr_r1_rsp_valid),
    .r1_rsp_status(rr_r1_rsp_status), .r1_rsp_data(rr_r1_rsp_data),
    .pkt_type(rr_pkt_type), .pkt_func_num(rr_pkt_func_num), .pkt_reg_num(rr_pkt_reg_num),
    .pkt_1dw_be(rr_pkt_1dw_be), .pkt_msg_routing(rr_pkt_msg_routing),
    .pkt_msg_code(rr_pkt_msg_code), .pkt_data(rr_pkt_data), .pkt_start(rr_pkt_start),
    .pkt_done(rr_pkt_done), .cpl_sc(rr_cpl_sc), .cpl_ur(1'b0), .cpl_crs(1'b0),
    .cpl_ca(1'b0), .cpl_mismatch(1'b0), .cpl_data(32'h0), .busy(rr_busy), .owner(rr_owner)
  );

  // Free-running cycle counter used for latency measurements.
  always @(posedge user_clk) cyc <= cyc + 1;

  // Observe handshakes on the falling edge, well away from the active edge.
  always @(negedge user_clk) begin
    if (pkt_start) start_cnt <= start_cnt + 1;
    if (r0_req_ready) r0_acc_cnt <= r0_acc_cnt + 1;
    if (r1_req_ready) begin
      r1_acc_cnt <= r1_acc_cnt + 1;
      r1_acc_cyc <= cyc;
    end
    if (r0_rsp_valid) begin
      r0_rsp_cnt <= r0_rsp_cnt + 1;
      r0_rsp_cyc <= cyc;
    end
    if (r1_rsp_valid) r1_rsp_cnt <= r1_rsp_cnt + 1;
    if (rr_pkt_start) rr_start_cnt <= rr_start_cnt + 1;
    if (rr_r0_req_ready) rr_r0_acc <= rr_r0_acc + 1;
    if (rr_r1_req_ready) rr_r1_acc <= rr_r1_acc + 1;
    if (rr_r0_rsp_valid) rr_r0_rsp_cnt <= rr_r0_rsp_cnt + 1;
    if (rr_r1_rsp_valid) rr_r1_rsp_cnt <= rr_r1_rsp_cnt + 1;
  end

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Raise a request: ports 0/1 go to the main instance, 2/3 to the round-robin one.
  task automatic applyStimulus(input int port, input logic [17:0] hdr, input logic [31:0] data);
    case (port)
      0: begin r0_req_valid = 1'b1; r0_req_hdr = hdr; r0_req_data = data; end
      1: begin r1_req_valid = 1'b1; r1_req_hdr = hdr; r1_req_data = data; end
      2: rr_r0_req_valid = 1'b1;
      default: rr_r1_req_valid = 1'b1;
    endcase
  endtask

  // Advance one cycle: strobes are single-cycle, and accepted requests drop valid.
  task automatic tick();
    @(posedge user_clk);
    #1;
    pkt_done = 1'b0; cpl_sc = 1'b0; cpl_ur = 1'b0; cpl_crs = 1'b0;
    cpl_ca = 1'b0; cpl_mismatch = 1'b0; rr_pkt_done = 1'b0; rr_cpl_sc = 1'b0;
    if (r0_acc_cnt != r0_acc_seen) begin r0_req_valid = 1'b0; r0_acc_seen = r0_acc_cnt; end
    if (r1_acc_cnt != r1_acc_seen) begin r1_req_valid = 1'b0; r1_acc_seen = r1_acc_cnt; end
    if (rr_r0_acc != rr_r0_seen) begin rr_r0_req_valid = 1'b0; rr_r0_seen = rr_r0_acc; end
    if (rr_r1_acc != rr_r1_seen) begin rr_r1_req_valid = 1'b0; rr_r1_seen = rr_r1_acc; end
  endtask

  function automatic int getCount(input int which);
    case (which)
      0: return start_cnt;
      1: return r0_rsp_cnt;
      2: return r1_rsp_cnt;
      3: return rr_start_cnt;
      4: return rr_r0_rsp_cnt;
      5: return rr_r1_rsp_cnt;
      6: return rr_r0_acc;
      7: return rr_r1_acc;
      8: return r0_acc_cnt;
      default: return r1_acc_cnt;
    endcase
  endfunction

  // Bounded wait for an event counter to reach a target, then check it exactly.
  task automatic awaitCount(input int which, input int target, input string tag);
    for (int i = 0; i < 60; i++) begin
      if (getCount(which) >= target) break;
      tick();
    end
    checkOutput(tag, getCount(which), target);
  endtask

  // Directed sequence of scenarios.
  initial begin
    reset_n = 1'b0;
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    r0_req_hdr = '0; r1_req_hdr = '0; r0_req_data = '0; r1_req_data = '0;
    pkt_done = 1'b0; cpl_sc = 1'b0; cpl_ur = 1'b0; cpl_crs = 1'b0;
    cpl_ca = 1'b0; cpl_mismatch = 1'b0; cpl_data = '0;
    rr_r0_req_valid = 1'b0; rr_r1_req_valid = 1'b0; rr_pkt_done = 1'b0; rr_cpl_sc = 1'b0;
    repeat (3) @(posedge user_clk);
    #1;
    r0_req_valid = 1'b1;
    #1;
    checkOutput("rst_ready", r0_req_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_owner", owner, 1'b0);
    checkOutput("rst_pkt_start", pkt_start, 1'b0);
    checkOutput("rst_rsp_status", r1_rsp_status, 3'd0);
    checkOutput("rst_rr_owner", rr_owner, 1'b0);
    r0_req_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // r1 CfgRd completed successfully
    applyStimulus(1, 18'h0004F, 32'h0);
    awaitCount(9, 1, "t1_accept");
    checkOutput("t1_owner", owner, 1'b1);
    checkOutput("t1_reg", pkt_reg_num, 10'h004);
    checkOutput("t1_be", pkt_1dw_be, 4'hF);
    awaitCount(0, 1, "t1_start");
    pkt_done = 1'b1; tick();
    cpl_sc = 1'b1; cpl_data = 32'hDEADBEEF;
    awaitCount(2, 1, "t1_rsp");
    checkOutput("t1_status", r1_rsp_status, 3'd0);
    checkOutput("t1_data", r1_rsp_data, 32'hDEADBEEF);
    checkOutput("t1_starts", start_cnt, 1);
    checkOutput("t1_r0_rsp", r0_rsp_cnt, 0);

    // Fixed priority contention: r0 first, r1 in the idle cycle after r0's response
    applyStimulus(0, 18'h1010F, 32'h11112222);
    applyStimulus(1, 18'h0004F, 32'h0);
    awaitCount(8, 1, "t2_r0_accept");
    checkOutput("t2_owner0", owner, 1'b0);
    checkOutput("t2_r1_wait", r1_acc_cnt, 1);
    checkOutput("t2_type", pkt_type, 2'd1);
    checkOutput("t2_pdata", pkt_data, 32'h11112222);
    awaitCount(0, 2, "t2_start0");
    pkt_done = 1'b1; tick();
    cpl_sc = 1'b1; cpl_data = 32'h00001234;
    awaitCount(1, 1, "t2_r0_rsp");
    awaitCount(9, 2, "t2_r1_accept");
    checkOutput("t2_gap", r1_acc_cyc - r0_rsp_cyc, 1);
    checkOutput("t2_owner1", owner, 1'b1);
    awaitCount(0, 3, "t2_start1");
    pkt_done = 1'b1; tick();
    cpl_sc = 1'b1; cpl_data = 32'hCAFE0001;
    awaitCount(2, 2, "t2_r1_rsp");
    checkOutput("t2_r1_data", r1_rsp_data, 32'hCAFE0001);
    checkOutput("t2_r0_hold", r0_rsp_data, 32'h00001234);

    // r0 CfgWr: three CRS then SC gives four pkt_start pulses
    applyStimulus(0, 18'h1010F, 32'hA5A5A5A5);
    awaitCount(0, 4, "t3_start0");
    for (int i = 0; i < 3; i++) begin
      pkt_done = 1'b1; tick();
      cpl_crs = 1'b1;
      awaitCount(0, 5 + i, "t3_retry");
    end
    pkt_done = 1'b1; tick();
    cpl_sc = 1'b1; cpl_data = 32'h0;
    awaitCount(1, 2, "t3_rsp");
    checkOutput("t3_starts", start_cnt, 7);
    checkOutput("t3_status", r0_rsp_status, 3'd0);

    // r0 CfgWr: nine CRS exhausts the eight retries
    applyStimulus(0, 18'h1010F, 32'h5A5A5A5A);
    awaitCount(0, 8, "t4_start0");
    for (int i = 0; i < 9; i++) begin
      pkt_done = 1'b1; tick();
      cpl_crs = 1'b1;
      if (i < 8) awaitCount(0, 9 + i, "t4_retry");
    end
    awaitCount(1, 3, "t4_rsp");
    checkOutput("t4_starts", start_cnt, 16);
    checkOutput("t4_status", r0_rsp_status, 3'd3);
    checkOutput("t4_data", r0_rsp_data, 32'h0);

    // r1 message: responds right after pkt_done, later completion ignored
    applyStimulus(1, 18'h2047F, 32'h87654321);
    awaitCount(0, 17, "t5_start");
    checkOutput("t5_route", pkt_msg_routing, 3'h4);
    checkOutput("t5_code", pkt_msg_code, 8'h7F);
    pkt_done = 1'b1; tick();
    checkOutput("t5_rsp_valid", r1_rsp_valid, 1'b1);
    checkOutput("t5_status", r1_rsp_status, 3'd0);
    checkOutput("t5_data", r1_rsp_data, 32'h0);
    tick();
    cpl_sc = 1'b1; cpl_data = 32'hFFFFFFFF;
    tick(); tick();
    checkOutput("t5_rsp_cnt", r1_rsp_cnt, 3);
    checkOutput("t5_idle", busy, 1'b0);

    // r0 CfgRd with no completion times out 20 cycles after entering the wait
    applyStimulus(0, 18'h0004F, 32'h0);
    awaitCount(0, 18, "t6_start");
    pkt_done = 1'b1; tick();
    t_entry = cyc;
    awaitCount(1, 4, "t6_rsp");
    checkOutput("t6_status", r0_rsp_status, 3'd5);
    checkOutput("t6_latency", r0_rsp_cyc - t_entry, 20);

    // UR arriving on the timeout cycle wins over timeout
    applyStimulus(0, 18'h0004F, 32'h0);
    awaitCount(0, 19, "t7_start");
    pkt_done = 1'b1; tick();
    t_entry = cyc;
    repeat (19) tick();
    cpl_ur = 1'b1;
    awaitCount(1, 5, "t7_rsp");
    checkOutput("t7_status", r0_rsp_status, 3'd1);
    checkOutput("t7_latency", r0_rsp_cyc - t_entry, 20);

    // SC and UR together: SC has priority
    applyStimulus(1, 18'h0004F, 32'h0);
    awaitCount(0, 20, "t8_start");
    pkt_done = 1'b1; tick();
    cpl_sc = 1'b1; cpl_ur = 1'b1; cpl_data = 32'h5555AAAA;
    awaitCount(2, 4, "t8_rsp");
    checkOutput("t8_status", r1_rsp_status, 3'd0);
    checkOutput("t8_data", r1_rsp_data, 32'h5555AAAA);

    // Reset while waiting for a completion abandons the transaction
    applyStimulus(1, 18'h0004F, 32'h0);
    awaitCount(0, 21, "t9_start");
    pkt_done = 1'b1; tick();
    checkOutput("t9_in_cpl", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("t9_busy", busy, 1'b0);
    checkOutput("t9_owner", owner, 1'b0);
    checkOutput("t9_rsp_data", r1_rsp_data, 32'h0);
    checkOutput("t9_reg", pkt_reg_num, 10'h0);
    tick(); tick();
    checkOutput("t9_no_rsp", r1_rsp_cnt, 4);
    reset_n = 1'b1;
    tick();
    applyStimulus(0, 18'h0004F, 32'h0);
    awaitCount(0, 22, "t9_start2");
    pkt_done = 1'b1; tick();
    cpl_sc = 1'b1; cpl_data = 32'h0BADF00D;
    awaitCount(1, 6, "t9_rsp2");
    checkOutput("t9_status2", r0_rsp_status, 3'd0);
    checkOutput("t9_data2", r0_rsp_data, 32'h0BADF00D);

    // Round-robin instance: back-to-back ties alternate r0, r1, r0, then r1 served
    applyStimulus(2, 18'h0, 32'h0);
    applyStimulus(3, 18'h0, 32'h0);
    awaitCount(6, 1, "rr1_acc");
    checkOutput("rr1_owner", rr_owner, 1'b0);
    checkOutput("rr1_r1_wait", rr_r1_acc, 0);
    awaitCount(3, 1, "rr1_start");
    rr_pkt_done = 1'b1; tick();
    rr_cpl_sc = 1'b1;
    awaitCount(4, 1, "rr1_rsp");
    applyStimulus(2, 18'h0, 32'h0);
    awaitCount(7, 1, "rr2_acc");
    checkOutput("rr2_owner", rr_owner, 1'b1);
    checkOutput("rr2_r0_wait", rr_r0_acc, 1);
    awaitCount(3, 2, "rr2_start");
    rr_pkt_done = 1'b1; tick();
    rr_cpl_sc = 1'b1;
    awaitCount(5, 1, "rr2_rsp");
    applyStimulus(3, 18'h0, 32'h0);
    awaitCount(6, 2, "rr3_acc");
    checkOutput("rr3_owner", rr_owner, 1'b0);
    checkOutput("rr3_r1_wait", rr_r1_acc, 1);
    awaitCount(3, 3, "rr3_start");
    rr_pkt_done = 1'b1; tick();
    rr_cpl_sc = 1'b1;
    awaitCount(4, 2, "rr3_rsp");
    awaitCount(7, 2, "rr4_acc");
    checkOutput("rr4_owner", rr_owner, 1'b1);
    awaitCount(3, 4, "rr4_start");
    rr_pkt_done = 1'b1; tick();
    rr_cpl_sc = 1'b1;
    awaitCount(5, 2, "rr4_rsp");
    checkOutput("rr4_status", rr_r1_rsp_status, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
